acs_unit: RTL and testbench
===========================

// Module: acs_unit
// PURPOSE
//   Add-compare-select stage of the K=3, rate-1/2 Viterbi decoder (generators G0=7, G1=5).
//   Sits between the branch-metric unit and the survivor memory; advances one trellis step
//   per en_add pulse from ctrl.
//   Keeps four path metrics, emits one decision bit per state (written to survivor memory
//   under en_mem) and the current best state (start point for traceback under en_tbck).
// PARAMETERS
//   BMW        2   branch metric width (Hamming distance 0..2 for hard decision, max 3)
//   PMW        6   path metric width; MSB (weight 2^(PMW-1)) is used for normalisation
//   INIT_BIAS  8   initial metric of states 1..3 at reset/start (state 0 starts at 0)
//   FRAME_LEN  16  trellis steps per frame; CW = $clog2(FRAME_LEN)
// PORTS
//   clk         in   1        system clock, rising edge
//   rst         in   1        asynchronous, active-high reset
//   en_add      in   1        step strobe from ctrl; one trellis step per cycle while high
//   start       in   1        synchronous re-init of metrics and step counter
//   bm_00..11   in   BMW      branch metric for expected code pair {c0,c1} = 00/01/10/11
//   dec         out  4        dec[ns] = LSB of the surviving predecessor of state ns
//   dec_valid   out  1        dec/best_state/pm_flat hold a new step result
//   best_state  out  2        state index with the minimum new path metric
//   pm_flat     out  4*PMW    {pm3,pm2,pm1,pm0} path metric registers
//   step_cnt    out  CW       steps accepted since start, modulo FRAME_LEN
//   frame_done  out  1        one-cycle pulse with dec_valid of step number FRAME_LEN
// BEHAVIOUR
//   Reset (async): pm0=0, pm1..3=INIT_BIAS; dec=0, dec_valid=0, best_state=0, step_cnt=0,
//   frame_done=0.
//   Trellis: state s={b1,b0}; input u -> next ns={u,s[1]}; c0=u^s[1]^s[0], c1=u^s[0].
//   Predecessors of ns={u,m}: pa={m,0}, pb={m,1}.
//   ACS per ns: ma=pm[pa]+bm(pa->ns), mb=pm[pb]+bm(pb->ns); widen to PMW+1 bits.
//   Choose pb only if mb<ma; tie selects pa (dec[ns]=0).
//   Normalisation: if all four new metrics >= 2^(PMW-1), subtract 2^(PMW-1) from each.
//   Otherwise store unchanged. Metric spread <= 8 and PMW=6, so no overflow is possible.
//   best_state: lowest index among minimum new metrics (computed on normalised values).
//   Latency: en_add sampled at edge N -> pm/dec/best_state update and dec_valid=1 after edge N.
//   dec_valid is high exactly one cycle per accepted step; it drops the cycle after en_add falls.
//   dec/best_state hold their last values while idle.
//   en_add=0: metrics and counter hold; dec_valid=0.
//   start=1: pm reinit as at reset, step_cnt=0, dec_valid=0. start has priority; a
//   coincident en_add is dropped.
//   step_cnt: increments per accepted step and wraps FRAME_LEN-1 -> 0.
//   frame_done=1 in the same cycle as dec_valid of the wrap step. Metrics are NOT reinit
//   at frame wrap.
//   Reset asserted mid-frame: immediate return to reset values; no partial update survives.
// TESTING
//   1 Reset: hold rst 20ns -> pm_flat={8,8,8,0}, dec_valid=0, step_cnt=0, all outputs 0.
//   2 Single step after start, bm_00=0 others=2 -> next cycle pm={10,2,10,0} (pm3..pm0),
//     dec=4'b0000, best_state=0, dec_valid=1 for one cycle.
//   3 Normalisation: bm all=3, en_add held 11 steps from start.
//     -> steps 2..10 give all pm=3k (step 10 = 30); step 11 gives all pm=1.
//   4 Frame: en_add held 16 steps -> step_cnt 1..15 then 0; frame_done high only with the
//     16th dec_valid; metrics continue.
//   5 start and en_add high in the same cycle mid-frame -> pm={8,8,8,0}, step_cnt=0,
//     no dec_valid.
//     Gap in en_add -> outputs hold, dec_valid=0.
//   6 rst pulse mid-step (between edges) -> outputs clear asynchronously; the next en_add
//     after release behaves as scenario 2.

Source files
------------

// File: rtl/acs_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : acs_unit_if
// Brief    : Interface bundling the control strobes, branch metrics and step
//            results of the Viterbi add-compare-select stage.
// Revision : 1.0 - initial release
// ============================================================================
interface acs_unit_if #(
  parameter int BMW = 2,
  parameter int PMW = 6,
  parameter int CW  = 4
);
  logic              en_add_i;
  logic              start_i;
  logic [BMW-1:0]    bm_00_i;
  logic [BMW-1:0]    bm_01_i;
  logic [BMW-1:0]    bm_10_i;
  logic [BMW-1:0]    bm_11_i;
  logic [3:0]        dec_o;
  logic              dec_valid_o;
  logic [1:0]        best_state_o;
  logic [4*PMW-1:0]  pm_flat_o;
  logic [CW-1:0]     step_cnt_o;
  logic              frame_done_o;

  // Control / branch-metric source side
  modport master (
    output en_add_i, start_i, bm_00_i, bm_01_i, bm_10_i, bm_11_i,
    input  dec_o, dec_valid_o, best_state_o, pm_flat_o, step_cnt_o, frame_done_o
  );

  // ACS stage side
  modport slave (
    input  en_add_i, start_i, bm_00_i, bm_01_i, bm_10_i, bm_11_i,
    output dec_o, dec_valid_o, best_state_o, pm_flat_o, step_cnt_o, frame_done_o
  );
endinterface
`default_nettype wire

// File: rtl/acs_unit.sv
`default_nettype none
// ============================================================================
// Module   : acs_unit
// Brief    : Add-compare-select stage for the K=3, rate-1/2 (7,5) Viterbi
//            decoder. Four path metrics, one decision bit per state, best
//            state tracking, MSB-based metric normalisation, frame counter.
// Revision : 1.0 - initial release
// ============================================================================
module acs_unit #(
  parameter int BMW       = 2,
  parameter int PMW       = 6,
  parameter int INIT_BIAS = 8,
  parameter int FRAME_LEN = 16
) (
  input  logic       clk,
  input  logic       rst,
  acs_unit_if.slave  bus
);

  localparam int             CW     = $clog2(FRAME_LEN);
  localparam int             NW     = PMW + 1;
  localparam logic [NW-1:0]  C_HALF = NW'(2 ** (PMW - 1));
  localparam logic [PMW-1:0] C_BIAS = PMW'(INIT_BIAS);
  localparam logic [CW-1:0]  C_LAST = CW'(FRAME_LEN - 1);

  // Branch metrics indexed by the code pair {c0,c1}
  logic [BMW-1:0] bm [4];
  assign bm[0] = bus.bm_00_i;
  assign bm[1] = bus.bm_01_i;
  assign bm[2] = bus.bm_10_i;
  assign bm[3] = bus.bm_11_i;

  logic [PMW-1:0] pm_q [4];
  logic [PMW-1:0] pm_d [4];
  logic [NW-1:0]  acs_new [4];
  logic [NW-1:0]  norm_full [4];
  logic [3:0]     dec_q, dec_d;
  logic [1:0]     best_q, best_d;
  logic           dec_valid_q;
  logic           frame_done_q;
  logic [CW-1:0]  cnt_q;
  logic           all_hi;
  logic [PMW-1:0] min_v;

  // One ACS butterfly half per next state ns={u,m}; predecessors {m,0}/{m,1}.
  // The pb branch always carries the bitwise-inverted code of the pa branch.
  for (genvar ns = 0; ns < 4; ns++) begin : g_acs
    localparam int U  = ns / 2;
    localparam int M  = ns % 2;
    localparam int PA = M * 2;
    localparam int PB = M * 2 + 1;
    localparam int CA = ((U ^ M) * 2) + U;
    localparam int CB = 3 - CA;
    logic [NW-1:0] ma, mb;
    assign ma          = NW'(pm_q[PA]) + NW'(bm[CA]);
    assign mb          = NW'(pm_q[PB]) + NW'(bm[CB]);
    assign dec_d[ns]   = (mb < ma);          // tie keeps pa
    assign acs_new[ns] = (mb < ma) ? mb : ma;
  end

  // Normalise when every metric has its MSB weight set, then pick the best state
  always_comb begin
    all_hi = 1'b1;
    for (int i = 0; i < 4; i++) begin
      all_hi = all_hi & (acs_new[i] >= C_HALF);
    end
    for (int i = 0; i < 4; i++) begin
      norm_full[i] = all_hi ? (acs_new[i] - C_HALF) : acs_new[i];
      pm_d[i]      = norm_full[i][PMW-1:0];
    end
    best_d = 2'd0;
    min_v  = pm_d[0];
    for (int i = 1; i < 4; i++) begin
      if (pm_d[i] < min_v) begin
        min_v  = pm_d[i];
        best_d = 2'(i);
      end
    end
  end

  // Metric, decision and counter registers; start outranks a coincident step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pm_q[0]      <= '0;
      pm_q[1]      <= C_BIAS;
      pm_q[2]      <= C_BIAS;
      pm_q[3]      <= C_BIAS;
      dec_q        <= '0;
      best_q       <= '0;
      dec_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      cnt_q        <= '0;
    end else if (bus.start_i) begin
      pm_q[0]      <= '0;
      pm_q[1]      <= C_BIAS;
      pm_q[2]      <= C_BIAS;
      pm_q[3]      <= C_BIAS;
      dec_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      cnt_q        <= '0;
    end else if (bus.en_add_i) begin
      for (int i = 0; i < 4; i++) begin
        pm_q[i] <= pm_d[i];
      end
      dec_q        <= dec_d;
      best_q       <= best_d;
      dec_valid_q  <= 1'b1;
      frame_done_q <= (cnt_q == C_LAST);
      cnt_q        <= (cnt_q == C_LAST) ? '0 : cnt_q + 1'b1;
    end else begin
      dec_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end
  end

  assign bus.dec_o        = dec_q;
  assign bus.dec_valid_o  = dec_valid_q;
  assign bus.best_state_o = best_q;
  assign bus.pm_flat_o    = {pm_q[3], pm_q[2], pm_q[1], pm_q[0]};
  assign bus.step_cnt_o   = cnt_q;
  assign bus.frame_done_o = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_acs_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_acs_unit
// Brief    : Directed self-checking bench for acs_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acs_unit;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  acs_unit_if #(.BMW(2), .PMW(6), .CW(4)) bus ();

  acs_unit #(
    .BMW(2), .PMW(6), .INIT_BIAS(8), .FRAME_LEN(16)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety bound on total run time
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, time=%0t", $time);
    $fatal(1, "timeout");
  end

  task automatic set_bm(input logic [1:0] b00, input logic [1:0] b01,
                        input logic [1:0] b10, input logic [1:0] b11);
    bus.bm_00_i = b00;
    bus.bm_01_i = b01;
    bus.bm_10_i = b10;
    bus.bm_11_i = b11;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.en_add_i = 1'b0;
    @(negedge clk);
    bus.start_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #20;
    checks++;
    if (bus.pm_flat_o !== {6'd8, 6'd8, 6'd8, 6'd0}) begin
      failures++; $display("FAIL reset_pm got=%h exp=%h", bus.pm_flat_o, {6'd8, 6'd8, 6'd8, 6'd0});
    end
    checks++;
    if ({bus.dec_valid_o, bus.frame_done_o, bus.step_cnt_o, bus.dec_o, bus.best_state_o} !== 12'd0) begin
      failures++; $display("FAIL reset_outs got vld=%b fd=%b cnt=%0d dec=%b best=%0d exp all 0",
        bus.dec_valid_o, bus.frame_done_o, bus.step_cnt_o, bus.dec_o, bus.best_state_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_step();
    pulse_start();
    set_bm(2'd0, 2'd2, 2'd2, 2'd2);
    bus.en_add_i = 1'b1;
    @(negedge clk);
    bus.en_add_i = 1'b0;
    checks++;
    if (bus.pm_flat_o !== {6'd10, 6'd2, 6'd10, 6'd0}) begin
      failures++; $display("FAIL single_pm got=%h exp=%h", bus.pm_flat_o, {6'd10, 6'd2, 6'd10, 6'd0});
    end
    checks++;
    if ({bus.dec_o, bus.best_state_o, bus.dec_valid_o, bus.step_cnt_o} !== {4'b0000, 2'd0, 1'b1, 4'd1}) begin
      failures++; $display("FAIL single_ctl got dec=%b best=%0d vld=%b cnt=%0d exp dec=0000 best=0 vld=1 cnt=1",
        bus.dec_o, bus.best_state_o, bus.dec_valid_o, bus.step_cnt_o);
    end
    @(negedge clk);
    checks++;
    if ({bus.dec_valid_o, bus.pm_flat_o} !== {1'b0, 6'd10, 6'd2, 6'd10, 6'd0}) begin
      failures++; $display("FAIL single_idle got vld=%b pm=%h exp vld=0 pm=%h",
        bus.dec_valid_o, bus.pm_flat_o, {6'd10, 6'd2, 6'd10, 6'd0});
    end
  endtask

  task automatic test_select();
    pulse_start();
    set_bm(2'd3, 2'd0, 2'd3, 2'd0);
    bus.en_add_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.pm_flat_o, bus.dec_o, bus.best_state_o} !== {6'd8, 6'd0, 6'd8, 6'd3, 4'b0010, 2'd2}) begin
      failures++; $display("FAIL select1 got pm=%h dec=%b best=%0d exp pm=%h dec=0010 best=2",
        bus.pm_flat_o, bus.dec_o, bus.best_state_o, {6'd8, 6'd0, 6'd8, 6'd3});
    end
    @(negedge clk);
    bus.en_add_i = 1'b0;
    checks++;
    if ({bus.pm_flat_o, bus.dec_o, bus.best_state_o, bus.dec_valid_o} !== {6'd0, 6'd3, 6'd3, 6'd6, 4'b0000, 2'd3, 1'b1}) begin
      failures++; $display("FAIL select2 got pm=%h dec=%b best=%0d vld=%b exp pm=%h dec=0000 best=3 vld=1",
        bus.pm_flat_o, bus.dec_o, bus.best_state_o, bus.dec_valid_o, {6'd0, 6'd3, 6'd3, 6'd6});
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.pm_flat_o, bus.best_state_o, bus.dec_valid_o, bus.step_cnt_o} !== {6'd0, 6'd3, 6'd3, 6'd6, 2'd3, 1'b0, 4'd2}) begin
      failures++; $display("FAIL gap_hold got pm=%h best=%0d vld=%b cnt=%0d exp pm=%h best=3 vld=0 cnt=2",
        bus.pm_flat_o, bus.best_state_o, bus.dec_valid_o, bus.step_cnt_o, {6'd0, 6'd3, 6'd3, 6'd6});
    end
  endtask

  task automatic test_normalise();
    logic [5:0] e;
    pulse_start();
    set_bm(2'd3, 2'd3, 2'd3, 2'd3);
    bus.en_add_i = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 11) bus.en_add_i = 1'b0;
      e = (k == 11) ? 6'd1 : 6'(3 * k);
      checks++;
      if (k == 1) begin
        if (bus.pm_flat_o !== {6'd11, 6'd3, 6'd11, 6'd3}) begin
          failures++; $display("FAIL norm_step1 got=%h exp=%h", bus.pm_flat_o, {6'd11, 6'd3, 6'd11, 6'd3});
        end
      end else if (bus.pm_flat_o !== {e, e, e, e}) begin
        failures++; $display("FAIL norm_step%0d got=%h exp=%h", k, bus.pm_flat_o, {e, e, e, e});
      end
    end
    checks++;
    if (bus.step_cnt_o !== 4'd11) begin
      failures++; $display("FAIL norm_cnt got=%0d exp=11", bus.step_cnt_o);
    end
  endtask

  task automatic test_frame();
    pulse_start();
    set_bm(2'd3, 2'd3, 2'd3, 2'd3);
    bus.en_add_i = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 16) bus.en_add_i = 1'b0;
      checks++;
      if ({bus.step_cnt_o, bus.frame_done_o, bus.dec_valid_o} !== {4'(k % 16), (k == 16), 1'b1}) begin
        failures++; $display("FAIL frame_step%0d got cnt=%0d fd=%b vld=%b exp cnt=%0d fd=%b vld=1",
          k, bus.step_cnt_o, bus.frame_done_o, bus.dec_valid_o, k % 16, (k == 16));
      end
    end
    checks++;
    if (bus.pm_flat_o !== {6'd16, 6'd16, 6'd16, 6'd16}) begin
      failures++; $display("FAIL frame_pm got=%h exp=%h", bus.pm_flat_o, {6'd16, 6'd16, 6'd16, 6'd16});
    end
    @(negedge clk);
    checks++;
    if ({bus.frame_done_o, bus.dec_valid_o, bus.step_cnt_o} !== {1'b0, 1'b0, 4'd0}) begin
      failures++; $display("FAIL frame_after got fd=%b vld=%b cnt=%0d exp fd=0 vld=0 cnt=0",
        bus.frame_done_o, bus.dec_valid_o, bus.step_cnt_o);
    end
  endtask

  task automatic test_start_collision();
    pulse_start();
    set_bm(2'd3, 2'd3, 2'd3, 2'd3);
    bus.en_add_i = 1'b1;
    repeat (3) @(negedge clk);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i  = 1'b0;
    bus.en_add_i = 1'b0;
    checks++;
    if ({bus.pm_flat_o, bus.step_cnt_o, bus.dec_valid_o} !== {6'd8, 6'd8, 6'd8, 6'd0, 4'd0, 1'b0}) begin
      failures++; $display("FAIL collision got pm=%h cnt=%0d vld=%b exp pm=%h cnt=0 vld=0",
        bus.pm_flat_o, bus.step_cnt_o, bus.dec_valid_o, {6'd8, 6'd8, 6'd8, 6'd0});
    end
  endtask

  task automatic test_async_reset();
    pulse_start();
    set_bm(2'd3, 2'd0, 2'd3, 2'd0);
    bus.en_add_i = 1'b1;
    @(negedge clk);
    bus.en_add_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.pm_flat_o !== {6'd8, 6'd8, 6'd8, 6'd0}) begin
      failures++; $display("FAIL arst_pm got=%h exp=%h", bus.pm_flat_o, {6'd8, 6'd8, 6'd8, 6'd0});
    end
    checks++;
    if ({bus.dec_o, bus.best_state_o, bus.dec_valid_o, bus.step_cnt_o} !== 11'd0) begin
      failures++; $display("FAIL arst_outs got dec=%b best=%0d vld=%b cnt=%0d exp all 0",
        bus.dec_o, bus.best_state_o, bus.dec_valid_o, bus.step_cnt_o);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    set_bm(2'd0, 2'd2, 2'd2, 2'd2);
    bus.en_add_i = 1'b1;
    @(negedge clk);
    bus.en_add_i = 1'b0;
    checks++;
    if ({bus.pm_flat_o, bus.dec_valid_o, bus.step_cnt_o} !== {6'd10, 6'd2, 6'd10, 6'd0, 1'b1, 4'd1}) begin
      failures++; $display("FAIL arst_step got pm=%h vld=%b cnt=%0d exp pm=%h vld=1 cnt=1",
        bus.pm_flat_o, bus.dec_valid_o, bus.step_cnt_o, {6'd10, 6'd2, 6'd10, 6'd0});
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    bus.en_add_i = 1'b0;
    bus.start_i  = 1'b0;
    set_bm(2'd0, 2'd0, 2'd0, 2'd0);
    test_reset();
    test_single_step();
    test_select();
    test_normalise();
    test_frame();
    test_start_collision();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
